// File: rtl/alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// alu_rr_scheduler
//   Shares a single alu among NUM_REQ client blocks. Requests are arbitrated
//   round-robin, the winning operands are driven onto the alu, the result is
//   captured after ALU_LAT clock edges and handed back to the winning client
//   through a per-requester response handshake. Only one op is in flight.
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous active-low reset (0 = reset)
//   req_valid  per-requester op valid
//   req_ready  one-hot accept (IDLE only); op taken on valid & ready
//   req_a      operand A, 8-bit slice per requester
//   req_b      operand B, 8-bit slice per requester
//   req_sel    alu select, 4-bit slice per requester
//   rsp_valid  one-hot response valid for the granted requester
//   rsp_ready  per-requester response accept
//   rsp_out    captured result, qualified by rsp_valid
//   rsp_carry  captured carry, qualified by rsp_valid
//   alu_a      to alu operand A
//   alu_b      to alu operand B
//   alu_sel    to alu select
//   alu_out    from alu result
//   alu_carry  from alu carry
//   busy       high whenever an op is in flight (state != IDLE)
// ---------------------------------------------------------------------------
module alu_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [8*NUM_REQ-1:0]   req_a,
  input  logic [8*NUM_REQ-1:0]   req_b,
  input  logic [4*NUM_REQ-1:0]   req_sel,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [7:0]             rsp_out,
  output logic                   rsp_carry,
  output logic [7:0]             alu_a,
  output logic [7:0]             alu_b,
  output logic [3:0]             alu_sel,
  input  logic [7:0]             alu_out,
  input  logic                   alu_carry,
  output logic                   busy
);

  localparam int IDX_W = (NUM_REQ < 2) ? 1 : $clog2(NUM_REQ);
  // A zero-latency alu still needs a 1-bit counter to keep the logic uniform.
  localparam int CNT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   grant;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   winner;
  logic               found;
  logic [7:0]         win_a;
  logic [7:0]         win_b;
  logic [3:0]         win_sel;
  logic [NUM_REQ-1:0] winner_onehot;
  logic [NUM_REQ-1:0] grant_onehot;
  logic               rsp_fire;

  // Round-robin search starting just after the last served requester, so the
  // requester that was just served is considered last.
  always_comb begin
    int idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!found && req_valid[IDX_W'(idx)]) begin
        found  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

  // Operand slices of the current winner.
  always_comb begin
    win_a   = 8'(req_a >> (8 * winner));
    win_b   = 8'(req_b >> (8 * winner));
    win_sel = 4'(req_sel >> (4 * winner));
  end

  // One-hot forms of the arbitration winner and of the in-flight grant.
  always_comb begin
    winner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
    grant_onehot  = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant;
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs. Responses from non-granted requesters
  // are masked out so their rsp_ready has no effect.
  always_comb begin
    state_next = state;
    req_ready  = '0;
    rsp_valid  = '0;
    rsp_fire   = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (found) begin
          req_ready  = winner_onehot;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = grant_onehot;
        rsp_fire  = |(rsp_ready & grant_onehot);
        if (rsp_fire) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: alu operand registers, latency counter, result capture and the
  // round-robin pointer. alu_* only change on an accept, so they hold while
  // waiting and while idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      rsp_out    <= '0;
      rsp_carry  <= 1'b0;
      cnt        <= '0;
      grant      <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            alu_a   <= win_a;
            alu_b   <= win_b;
            alu_sel <= win_sel;
            grant   <= winner;
            cnt     <= CNT_W'(ALU_LAT);
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            rsp_out   <= alu_out;
            rsp_carry <= alu_carry;
          end
        end
        RESP: begin
          if (rsp_fire) begin
            last_grant <= grant;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_alu_rr_scheduler
//   Directed bench for alu_rr_scheduler. One instance uses a one-cycle
//   registered alu model (ALU_LAT=1), a second uses a combinational alu model
//   (ALU_LAT=0). Both share clock and reset.
// ---------------------------------------------------------------------------
module tb_alu_rr_scheduler;

  logic        clock;
  logic        reset;

  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [15:0] req_sel;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_ready;
  logic [7:0]  rsp_out;
  logic        rsp_carry;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_sel;
  logic [7:0]  alu_out;
  logic        alu_carry;
  logic        busy;

  logic [3:0]  z_req_valid;
  logic [3:0]  z_req_ready;
  logic [31:0] z_req_a;
  logic [31:0] z_req_b;
  logic [15:0] z_req_sel;
  logic [3:0]  z_rsp_valid;
  logic [3:0]  z_rsp_ready;
  logic [7:0]  z_rsp_out;
  logic        z_rsp_carry;
  logic [7:0]  z_alu_a;
  logic [7:0]  z_alu_b;
  logic [3:0]  z_alu_sel;
  logic [7:0]  z_alu_out;
  logic        z_alu_carry;
  logic        z_busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_rr_scheduler #(.NUM_REQ(4), .ALU_LAT(1)) u_dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out(rsp_out), .rsp_carry(rsp_carry),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .busy(busy)
  );

  alu_rr_scheduler #(.NUM_REQ(4), .ALU_LAT(0)) u_dut_z (
    .clock(clock), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_a(z_req_a), .req_b(z_req_b), .req_sel(z_req_sel),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_out(z_rsp_out), .rsp_carry(z_rsp_carry),
    .alu_a(z_alu_a), .alu_b(z_alu_b), .alu_sel(z_alu_sel),
    .alu_out(z_alu_out), .alu_carry(z_alu_carry),
    .busy(z_busy)
  );

  // Reference alu: returns {carry, result}. Carry is the carry of A+B.
  function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] sel);
    logic [8:0] s;
    logic [7:0] r;
    s = {1'b0, a} + {1'b0, b};
    case (sel)
      4'h0: r = s[7:0];
      4'h1: r = a - b;
      4'h2: r = 8'(a * b);
      4'h3: r = (b == 8'd0) ? 8'd0 : a / b;
      4'h4: r = a << 1;
      4'h5: r = a >> 1;
      4'h6: r = {a[6:0], a[7]};
      4'h7: r = {a[0], a[7:1]};
      4'h8: r = a & b;
      4'h9: r = a | b;
      4'hA: r = a ^ b;
      4'hB: r = ~(a | b);
      4'hC: r = ~(a & b);
      4'hD: r = ~(a ^ b);
      4'hE: r = (a > b) ? 8'd1 : 8'd0;
      default: r = (a == b) ? 8'd1 : 8'd0;
    endcase
    return {s[8], r};
  endfunction

  // Registered alu for the ALU_LAT=1 instance.
  always_ff @(posedge clock) begin
    {alu_carry, alu_out} <= alu_fn(alu_a, alu_b, alu_sel);
  end

  // Combinational alu for the ALU_LAT=0 instance.
  assign {z_alu_carry, z_alu_out} = alu_fn(z_alu_a, z_alu_b, z_alu_sel);

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic do_reset();
    reset       = 1'b0;
    req_valid   = '0;
    z_req_valid = '0;
    rsp_ready   = '1;
    z_rsp_ready = '1;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  // Counts negedges until the ALU_LAT=1 instance raises rsp_valid; -1 on timeout.
  task automatic wait_rsp(output int cyc);
    cyc = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      #1;
      if (rsp_valid != 4'b0000) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    req_valid   = '0;
    z_req_valid = '0;
    rsp_ready   = '1;
    z_rsp_ready = '1;
    req_a = '0; req_b = '0; req_sel = '0;
    z_req_a = '0; z_req_b = '0; z_req_sel = '0;
    @(negedge clock);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_busy got=%0b exp=0", busy);
    end
    n_checks++;
    if (rsp_valid !== 4'b0000) begin
      n_fail++; $display("[TB] FAIL reset_rsp_valid got=%b exp=0000", rsp_valid);
    end
    n_checks++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("[TB] FAIL reset_req_ready got=%b exp=0000", req_ready);
    end
    n_checks++;
    if ({alu_a, alu_b, alu_sel} !== 20'h0) begin
      n_fail++; $display("[TB] FAIL reset_alu got=%h/%h/%h exp=0", alu_a, alu_b, alu_sel);
    end
    n_checks++;
    if ({rsp_out, rsp_carry} !== 9'h0) begin
      n_fail++; $display("[TB] FAIL reset_rsp got=%h/%b exp=0", rsp_out, rsp_carry);
    end
    n_checks++;
    if (z_busy !== 1'b0 || z_rsp_valid !== 4'b0000) begin
      n_fail++; $display("[TB] FAIL reset_z got busy=%b rsp_valid=%b exp=0", z_busy, z_rsp_valid);
    end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_single_op();
    logic [3:0] exp_v;
    req_a[7:0]   = 8'hFF;
    req_b[7:0]   = 8'h01;
    req_sel[3:0] = 4'h0;
    rsp_ready    = '1;
    req_valid    = 4'b0001;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("[TB] FAIL single_ready got=%b exp=0001", req_ready);
    end
    for (int n = 1; n <= 3; n++) begin
      @(negedge clock);
      #1;
      if (n == 1) begin
        n_checks++;
        if (req_ready !== 4'b0000 || busy !== 1'b1) begin
          n_fail++; $display("[TB] FAIL single_ready_one_cycle got ready=%b busy=%b exp=0000/1",
                             req_ready, busy);
        end
        req_valid = 4'b0000;
      end
      exp_v = (n == 3) ? 4'b0001 : 4'b0000;
      n_checks++;
      if (rsp_valid !== exp_v) begin
        n_fail++; $display("[TB] FAIL single_rsp_valid cycle %0d got=%b exp=%b", n, rsp_valid, exp_v);
      end
    end
    n_checks++;
    if (rsp_out !== 8'h00 || rsp_carry !== 1'b1) begin
      n_fail++; $display("[TB] FAIL single_result got=%h/%b exp=00/1", rsp_out, rsp_carry);
    end
    @(negedge clock);
    #1;
    n_checks++;
    if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin
      n_fail++; $display("[TB] FAIL single_done got busy=%b rsp_valid=%b exp=0/0000", busy, rsp_valid);
    end
  endtask

  // Runs right after the single op: alu inputs must keep FF/01/0.
  task automatic test_idle();
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      #1;
      n_checks++;
      if ({busy, req_ready, alu_a, alu_b, alu_sel} !== {1'b0, 4'b0000, 8'hFF, 8'h01, 4'h0}) begin
        n_fail++; $display("[TB] FAIL idle cycle %0d got busy=%b ready=%b alu=%h/%h/%h exp=0/0000/ff/01/0",
                           n, busy, req_ready, alu_a, alu_b, alu_sel);
      end
    end
  endtask

  task automatic test_fairness();
    int         exp_order [5] = '{0, 1, 2, 3, 0};
    int         cyc;
    int         w;
    logic [8:0] exp_res;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_a[8*i +: 8]   = 8'(8'h10 * (i + 1) + 3);
      req_b[8*i +: 8]   = 8'(8'h05 + i);
      req_sel[4*i +: 4] = 4'(i);
    end
    rsp_ready = '1;
    req_valid = 4'b1111;
    for (int op = 0; op < 5; op++) begin
      if (op > 0) @(negedge clock);
      #1;
      w = exp_order[op];
      n_checks++;
      if (req_ready !== (4'b0001 << w)) begin
        n_fail++; $display("[TB] FAIL fair_grant op %0d got=%b exp=%b", op, req_ready, 4'b0001 << w);
      end
      exp_res = alu_fn(req_a[8*w +: 8], req_b[8*w +: 8], req_sel[4*w +: 4]);
      wait_rsp(cyc);
      n_checks++;
      if (cyc != 3) begin
        n_fail++; $display("[TB] FAIL fair_latency op %0d got=%0d exp=3", op, cyc);
      end
      n_checks++;
      if (rsp_valid !== (4'b0001 << w)) begin
        n_fail++; $display("[TB] FAIL fair_rsp_valid op %0d got=%b exp=%b", op, rsp_valid, 4'b0001 << w);
      end
      n_checks++;
      if ({rsp_carry, rsp_out} !== exp_res) begin
        n_fail++; $display("[TB] FAIL fair_result op %0d got=%b/%h exp=%b/%h",
                           op, rsp_carry, rsp_out, exp_res[8], exp_res[7:0]);
      end
    end
    req_valid = 4'b0000;
    @(negedge clock);
  endtask

  task automatic test_backpressure();
    int cyc;
    do_reset();
    req_a[15:8]  = 8'h20;
    req_b[15:8]  = 8'h07;
    req_sel[7:4] = 4'h1;
    rsp_ready    = 4'b0001;
    req_valid    = 4'b0010;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("[TB] FAIL bp_grant got=%b exp=0010", req_ready);
    end
    wait_rsp(cyc);
    n_checks++;
    if (cyc != 3) begin
      n_fail++; $display("[TB] FAIL bp_latency got=%0d exp=3", cyc);
    end
    req_valid = 4'b0101;
    for (int n = 0; n < 10; n++) begin
      #1;
      n_checks++;
      if (rsp_valid !== 4'b0010 || rsp_out !== 8'h19 || rsp_carry !== 1'b0 || req_ready !== 4'b0000) begin
        n_fail++; $display("[TB] FAIL bp_hold cycle %0d got valid=%b out=%h carry=%b ready=%b exp=0010/19/0/0000",
                           n, rsp_valid, rsp_out, rsp_carry, req_ready);
      end
      @(negedge clock);
    end
    rsp_ready = 4'b0010;
    @(negedge clock);
    #1;
    n_checks++;
    if (rsp_valid !== 4'b0000 || req_ready !== 4'b0100) begin
      n_fail++; $display("[TB] FAIL bp_release got valid=%b ready=%b exp=0000/0100", rsp_valid, req_ready);
    end
    req_valid = 4'b0000;
    rsp_ready = '1;
    @(negedge clock);
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    req_a[7:0]   = 8'h5A;
    req_b[7:0]   = 8'h33;
    req_sel[3:0] = 4'h8;
    req_valid    = 4'b0001;
    @(negedge clock);
    #1;
    n_checks++;
    if (busy !== 1'b1 || alu_a !== 8'h5A) begin
      n_fail++; $display("[TB] FAIL rw_accepted got busy=%b alu_a=%h exp=1/5a", busy, alu_a);
    end
    req_valid = 4'b0000;
    reset     = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin
      n_fail++; $display("[TB] FAIL rw_flush got busy=%b rsp_valid=%b exp=0/0000", busy, rsp_valid);
    end
    n_checks++;
    if ({alu_a, alu_b, alu_sel} !== 20'h0) begin
      n_fail++; $display("[TB] FAIL rw_alu_clear got=%h/%h/%h exp=0", alu_a, alu_b, alu_sel);
    end
    @(negedge clock);
    reset     = 1'b1;
    req_valid = 4'b0011;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("[TB] FAIL rw_first_grant got=%b exp=0001", req_ready);
    end
    req_valid = 4'b0000;
    @(negedge clock);
  endtask

  task automatic test_lat0();
    int         r;
    int         cyc;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] s;
    logic [8:0] exp_res;
    do_reset();
    z_rsp_ready = '1;
    for (int op = 0; op < 100; op++) begin
      r = $urandom_range(0, 3);
      a = 8'($urandom);
      b = 8'($urandom);
      s = 4'($urandom);
      z_req_a[8*r +: 8]   = a;
      z_req_b[8*r +: 8]   = b;
      z_req_sel[4*r +: 4] = s;
      z_req_valid         = 4'b0001 << r;
      exp_res             = alu_fn(a, b, s);
      #1;
      n_checks++;
      if (z_req_ready !== (4'b0001 << r)) begin
        n_fail++; $display("[TB] FAIL lat0_grant op %0d got=%b exp=%b", op, z_req_ready, 4'b0001 << r);
      end
      cyc = -1;
      for (int n = 1; n <= 20; n++) begin
        @(negedge clock);
        #1;
        if (n == 1) z_req_valid = 4'b0000;
        if (z_rsp_valid != 4'b0000) begin
          cyc = n;
          break;
        end
      end
      n_checks++;
      if (cyc != 2) begin
        n_fail++; $display("[TB] FAIL lat0_latency op %0d got=%0d exp=2", op, cyc);
      end
      n_checks++;
      if (z_rsp_valid !== (4'b0001 << r) || {z_rsp_carry, z_rsp_out} !== exp_res) begin
        n_fail++; $display("[TB] FAIL lat0_result op %0d got valid=%b res=%b/%h exp=%b/%b/%h",
                           op, z_rsp_valid, z_rsp_carry, z_rsp_out, 4'b0001 << r, exp_res[8], exp_res[7:0]);
      end
      @(negedge clock);
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_idle();
    test_fairness();
    test_backpressure();
    test_reset_in_wait();
    test_lat0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
